// File: rtl/mips_boot_pkg.sv
// mips_boot_pkg: shared state encoding and framing constants for the IM boot loader.
package mips_boot_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE} state_t;
    localparam int BYTES_PER_WORD = 4;
    function automatic int hdr_bytes(input int len_w);
        return len_w / 8;
    endfunction
endpackage

// File: rtl/boot_word_packer.sv
// boot_word_packer: packs bytes MSB-first into 32-bit words, pulsing word_valid the cycle after the 4th byte.
module boot_word_packer
    import mips_boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  in_byte,
    output logic        word_valid,
    output logic [31:0] word
);
    logic [1:0]  cnt;
    logic [23:0] sr;
    logic        last;
    assign last = cnt == 2'(BYTES_PER_WORD - 1);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt        <= '0;
            sr         <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= byte_en && last;
            if (byte_en) begin
                cnt <= cnt + 1'b1;
                sr  <= {sr[15:0], in_byte};
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) word <= '0;
        else if (byte_en && last) word <= {sr, in_byte};
    end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: length-prefixed byte stream -> big-endian words into IM, holding the core until loaded.
// Define BOOT_CHECKSUM_EN for a trailing XOR checksum byte and the err flag.
module imem_boot_loader
    import mips_boot_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              overflow,
    output logic              err
);
    localparam int HB   = hdr_bytes(LEN_W);
    localparam int HC_W = HB > 1 ? $clog2(HB) : 1;
`ifdef BOOT_CHECKSUM_EN
    localparam state_t AFTER_DATA = S_CSUM;
`else
    localparam state_t AFTER_DATA = S_DONE;
`endif
    state_t           state, state_n;
    logic [LEN_W-1:0] n, cnt;
    logic [HC_W-1:0]  hcnt;
    logic             fire, go, fin, in_range, last_hdr, word_valid;
    logic [31:0]      word;

    assign fire     = in_valid && in_ready;
    assign go       = start && (state == S_IDLE || state == S_DONE);
    assign last_hdr = hcnt == HC_W'(HB - 1);
    assign in_range = (cnt >> ADDR_W) == '0;
    // All words are in once the count reaches N, including the one the packer is emitting right now.
    assign fin      = cnt == n || (word_valid && {1'b0, cnt} + (LEN_W + 1)'(1) == {1'b0, n});
    assign in_ready = state == S_LEN || state == S_CSUM || (state == S_DATA && !fin);
    assign done     = state == S_DONE;
    assign cpu_hold = !(done && !err);
    assign im_we    = word_valid && in_range;
    assign im_addr  = in_range ? cnt[ADDR_W-1:0] : '1;
    assign im_wdata = word;

    boot_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (go),
        .byte_en    (fire && state == S_DATA),
        .in_byte    (in_byte),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_DONE: state_n = start ? S_LEN : state;
            S_LEN:          state_n = fire && last_hdr ? S_DATA : S_LEN;
            S_DATA:         state_n = fin ? AFTER_DATA : S_DATA;
            S_CSUM:         state_n = fire ? S_DONE : S_CSUM;
            default:        state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            n        <= '0;
            cnt      <= '0;
            hcnt     <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_n;
            if (go) begin
                n        <= '0;
                cnt      <= '0;
                hcnt     <= '0;
                overflow <= 1'b0;
            end else begin
                if (state == S_LEN && fire) begin
                    n    <= (n << 8) | LEN_W'(in_byte);
                    hcnt <= hcnt + 1'b1;
                end
                if (word_valid) begin
                    cnt <= cnt + 1'b1;
                    if (!in_range) overflow <= 1'b1;
                end
            end
        end
    end

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] csum;
    logic       err_q;
    always_ff @(posedge clk) begin
        if (rst || go) begin
            csum  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == S_DATA && fire) csum <= csum ^ in_byte;
            if (state == S_CSUM && fire) err_q <= csum != in_byte;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule
